// File: rtl/frame_scheduler.sv
// Frame scheduler: per-frame game sequencer.
// Every accepted frame_tick starts one frame sequence. The sequence runs the
// subsystem phases of the current game state one after another, each over a
// req/ack handshake.
//
// Handshake semantics (all four phases):
//   - The scheduler raises one req, and only one req is ever high.
//   - The req stays high until the scheduler samples ack=1 on a rising edge.
//   - At that edge the req drops and the next phase's req rises. Because the
//     reqs are registered, the new req is visible in the following cycle.
//   - An ack that arrives while its req is low has no effect.
//   - hit/passed are qualified only by coll_ack while coll_req is high.
//
// game_state is the externally visible state register. The active phase is
// visible as the one-hot set of req outputs.
module frame_scheduler #(
  parameter int SCORE_W      = 16,
  parameter int DEATH_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               flap,
  output logic               bird_req,
  input  logic               bird_ack,
  output logic               flap_out,
  output logic               pipe_req,
  input  logic               pipe_ack,
  output logic               coll_req,
  input  logic               coll_ack,
  input  logic               hit,
  input  logic               passed,
  output logic               draw_req,
  input  logic               draw_ack,
  output logic [1:0]         game_state,
  output logic [SCORE_W-1:0] score,
  output logic [31:0]        frame_cnt,
  output logic               busy,
  output logic               overrun
);

  localparam int DW = $clog2(DEATH_FRAMES + 1);
  localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t        state_q;
  logic          start_pend;
  logic          flap_pend;
  logic          hit_lat;
  logic [DW-1:0] death_cnt;

  logic          final_done;
  logic          accept;
  logic          begin_play;
  logic          bird_rise;
  state_t        eof_state;
  state_t        run_state;
  logic [DW-1:0] eof_death;

  assign game_state = state_q;

  // End-of-frame state update first, then the start of a coincident new frame.
  always_comb begin
    final_done = draw_req & draw_ack;
    accept     = frame_tick & (~busy | final_done);
    eof_state  = state_q;
    eof_death  = death_cnt;
    if (final_done) begin
      case (state_q)
        ST_PLAY: begin
          if (hit_lat) begin
            eof_state = ST_DYING;
            eof_death = '0;
          end
        end
        ST_DYING: begin
          eof_death = death_cnt + DW'(1);
          if (death_cnt == DEATH_LAST) eof_state = ST_OVER;
        end
        default: ;
      endcase
    end
    begin_play = accept & start_pend &
                 ((eof_state == ST_IDLE) || (eof_state == ST_OVER));
    run_state  = begin_play ? ST_PLAY : eof_state;
    bird_rise  = accept & ((run_state == ST_PLAY) || (run_state == ST_DYING));
  end

  // Game state, counters, score and the phase handshake sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      start_pend <= 1'b0;
      flap_pend  <= 1'b0;
      hit_lat    <= 1'b0;
      death_cnt  <= '0;
      bird_req   <= 1'b0;
      pipe_req   <= 1'b0;
      coll_req   <= 1'b0;
      draw_req   <= 1'b0;
      flap_out   <= 1'b0;
      score      <= '0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q   <= run_state;
      death_cnt <= eof_death;

      if (frame_tick) frame_cnt <= frame_cnt + 32'd1;
      if (frame_tick && !accept) overrun <= 1'b1;

      // A start is only remembered while no game is running.
      if (begin_play) begin
        start_pend <= 1'b0;
        score      <= '0;
      end else if (start && ((state_q == ST_IDLE) || (state_q == ST_OVER))) begin
        start_pend <= 1'b1;
      end

      // flap_pend is consumed as bird_req rises; a flap in that cycle refills it.
      if (bird_rise) flap_out <= flap_pend;
      flap_pend <= flap | (flap_pend & ~bird_rise);

      if (accept) begin
        busy     <= 1'b1;
        hit_lat  <= 1'b0;
        bird_req <= bird_rise;
        pipe_req <= 1'b0;
        coll_req <= 1'b0;
        draw_req <= ~bird_rise;
      end else begin
        if (bird_req && bird_ack) begin
          bird_req <= 1'b0;
          if (state_q == ST_PLAY) pipe_req <= 1'b1;
          else                    draw_req <= 1'b1;
        end
        if (pipe_req && pipe_ack) begin
          pipe_req <= 1'b0;
          coll_req <= 1'b1;
        end
        if (coll_req && coll_ack) begin
          coll_req <= 1'b0;
          draw_req <= 1'b1;
          if (hit) begin
            hit_lat <= 1'b1;
          end else if (passed && (score != '1)) begin
            score <= score + SCORE_W'(1);
          end
        end
        if (final_done) begin
          draw_req <= 1'b0;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: directed scenarios followed by randomized frames,
// checked against a frame-level game model.
module tb_frame_scheduler;

  localparam int SW = 4;
  localparam int DF = 2;
  localparam logic [3:0] P_BIRD = 4'b1000;
  localparam logic [3:0] P_PIPE = 4'b0100;
  localparam logic [3:0] P_COLL = 4'b0010;
  localparam logic [3:0] P_DRAW = 4'b0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_tick = 1'b0, start = 1'b0, flap = 1'b0;
  logic          bird_ack = 1'b0, pipe_ack = 1'b0, coll_ack = 1'b0, draw_ack = 1'b0;
  logic          hit = 1'b0, passed = 1'b0;
  logic          bird_req, pipe_req, coll_req, draw_req, flap_out, busy, overrun;
  logic [1:0]    game_state;
  logic [SW-1:0] score;
  logic [31:0]   frame_cnt;

  frame_scheduler #(.SCORE_W(SW), .DEATH_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .flap(flap),
    .bird_req(bird_req), .bird_ack(bird_ack), .flap_out(flap_out),
    .pipe_req(pipe_req), .pipe_ack(pipe_ack),
    .coll_req(coll_req), .coll_ack(coll_ack), .hit(hit), .passed(passed),
    .draw_req(draw_req), .draw_ack(draw_ack),
    .game_state(game_state), .score(score), .frame_cnt(frame_cnt),
    .busy(busy), .overrun(overrun)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game model: 0=IDLE 1=PLAY 2=DYING 3=OVER
  int          m_state;
  int          m_score;
  int          m_death;
  bit          m_pend;
  bit          m_flap;
  bit          m_ovr;
  logic [31:0] m_frames;
  logic [3:0]  exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] reqs();
    return {bird_req, pipe_req, coll_req, draw_req};
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_death = 0;
    m_pend = 0; m_flap = 0; m_ovr = 0; m_frames = '0;
  endtask

  // Asynchronous reset, asserted mid-cycle; called at a falling edge.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_reqs", 64'(reqs()), 64'(4'b0000));
    chk("rst_flap_out", 64'(flap_out), 64'(1'b0));
    chk("rst_state", 64'(game_state), 64'(2'd0));
    chk("rst_score", 64'(score), 64'(0));
    chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_overrun", 64'(overrun), 64'(1'b0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_state"}, 64'(game_state), 64'(m_state));
    chk({tag, "_score"}, 64'(score), 64'(m_score));
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(m_frames));
    chk({tag, "_overrun"}, 64'(overrun), 64'(m_ovr));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    if (m_state == 0 || m_state == 3) m_pend = 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_flap();
    flap = 1'b1;
    m_flap = 1;
    @(negedge clk);
    flap = 1'b0;
  endtask

  // Idle cycles between frames with optional random start/flap and stray acks.
  task automatic gap(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        flap     = ($urandom_range(0, 3) == 0);
        start    = ($urandom_range(0, 5) == 0);
        bird_ack = ($urandom_range(0, 4) == 0);
        pipe_ack = ($urandom_range(0, 4) == 0);
        coll_ack = ($urandom_range(0, 4) == 0);
        draw_ack = ($urandom_range(0, 4) == 0);
        hit      = $urandom_range(0, 1);
        passed   = $urandom_range(0, 1);
        if (flap) m_flap = 1;
        if (start && (m_state == 0 || m_state == 3)) m_pend = 1;
      end
      @(negedge clk);
      {flap, start, bird_ack, pipe_ack, coll_ack, draw_ack, hit, passed} = '0;
    end
    chk("gap_reqs", 64'(reqs()), 64'(4'b0000));
    chk("gap_busy", 64'(busy), 64'(1'b0));
  endtask

  // One frame sequence. pre_ticked: the tick was already given with the last
  // draw_ack of the previous frame. ovr_phase: phase index during which an extra
  // tick arrives. chain: tick together with this frame's final draw_ack.
  // abort_phase: phase index at which reset is applied instead of acking.
  task automatic do_frame(input bit pre_ticked, input bit hit_i, input bit pass_i,
                          input int ovr_phase, input bit chain, input int abort_phase);
    int         idx = 0;
    bit         f_hit = 0;
    bit         last;
    logic [3:0] p;
    if (!pre_ticked) begin
      frame_tick = 1'b1;
      m_frames++;
      @(negedge clk);
      frame_tick = 1'b0;
    end
    if (m_pend && (m_state == 0 || m_state == 3)) begin
      m_state = 1; m_score = 0; m_pend = 0;
    end
    exp_q.delete();
    if (m_state == 1 || m_state == 2) exp_q.push_back(P_BIRD);
    if (m_state == 1) begin
      exp_q.push_back(P_PIPE);
      exp_q.push_back(P_COLL);
    end
    exp_q.push_back(P_DRAW);
    chk("busy_on", 64'(busy), 64'(1'b1));
    while (exp_q.size() > 0) begin
      p = exp_q.pop_front();
      last = (exp_q.size() == 0);
      chk($sformatf("req_phase%0d", idx), 64'(reqs()), 64'(p));
      if (p == P_BIRD) begin
        chk("flap_out", 64'(flap_out), 64'(m_flap));
        m_flap = 0;
      end
      if (idx == abort_phase) begin
        apply_reset();
        return;
      end
      if (idx == ovr_phase) begin
        frame_tick = 1'b1;
        m_frames++;
        m_ovr = 1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("req_hold_ovr", 64'(reqs()), 64'(p));
        chk("busy_hold_ovr", 64'(busy), 64'(1'b1));
      end
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("req_hold", 64'(reqs()), 64'(p));
      end
      case (p)
        P_BIRD: bird_ack = 1'b1;
        P_PIPE: pipe_ack = 1'b1;
        P_COLL: begin coll_ack = 1'b1; hit = hit_i; passed = pass_i; end
        default: draw_ack = 1'b1;
      endcase
      if (last && chain) begin
        frame_tick = 1'b1;
        m_frames++;
      end
      @(negedge clk);
      {bird_ack, pipe_ack, coll_ack, draw_ack, hit, passed, frame_tick} = '0;
      if (p == P_COLL) begin
        if (hit_i) f_hit = 1;
        else if (pass_i && m_score < (1 << SW) - 1) m_score++;
      end
      idx++;
    end
    if (m_state == 1 && f_hit) begin
      m_state = 2; m_death = 0;
    end else if (m_state == 2) begin
      m_death++;
      if (m_death == DF) m_state = 3;
    end
    if (!chain) begin
      chk("busy_off", 64'(busy), 64'(1'b0));
      chk("reqs_off", 64'(reqs()), 64'(4'b0000));
    end
    check_status("eof");
  endtask

  initial begin
    bit pre;
    model_reset();
    @(negedge clk);
    apply_reset();

    // IDLE frame: draw only
    do_frame(0, 0, 0, -1, 0, -1);
    gap(2, 0);

    // Start then a full PLAY frame
    pulse_start();
    do_frame(0, 0, 0, -1, 0, -1);
    gap(1, 0);
    pulse_start();  // ignored while playing

    // Flap carried into the next bird phase, then cleared
    pulse_flap();
    do_frame(0, 0, 0, -1, 0, -1);
    gap(1, 0);
    do_frame(0, 0, 0, -1, 0, -1);

    // Three passes, then pass+hit, then DYING frames to OVER
    for (int i = 0; i < 3; i++) do_frame(0, 0, 1, -1, 0, -1);
    do_frame(0, 1, 1, -1, 0, -1);
    do_frame(0, 0, 0, -1, 0, -1);
    do_frame(0, 0, 0, -1, 0, -1);
    do_frame(0, 0, 0, -1, 0, -1);  // OVER: draw only

    // Restart; tick during pipe phase; tick coincident with final draw_ack
    pulse_start();
    do_frame(0, 0, 1, 1, 0, -1);
    do_frame(0, 0, 1, -1, 1, -1);
    do_frame(1, 0, 1, -1, 0, -1);

    // Score saturation
    for (int i = 0; i < 16; i++) do_frame(0, 0, 1, -1, 0, -1);

    // Reset during the collision phase, then an IDLE draw-only frame
    do_frame(0, 0, 0, -1, 0, 2);
    do_frame(0, 0, 0, -1, 0, -1);

    // Randomized frames
    pre = 0;
    for (int i = 0; i < 80; i++) begin
      bit r_hit, r_pass, r_chain;
      int r_ovr;
      r_hit   = ($urandom_range(0, 7) == 0);
      r_pass  = $urandom_range(0, 1);
      r_ovr   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      r_chain = ($urandom_range(0, 3) == 0);
      do_frame(pre, r_hit, r_pass, r_ovr, r_chain, -1);
      pre = r_chain;
      if (!r_chain) gap($urandom_range(1, 4), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
